calc_seq_ctrl: RTL and testbench

//  Sequencer for the calculator's 4-bit ALU. Latches operand A/B from switches and an

---
 rtl/calc_pkg.sv | 43 ++++
 rtl/calc_edge_det.sv | 24 ++
 rtl/calc_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer:
// ALU op codes, status codes, FSM states.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_DIV = 4'd8;

  localparam logic [2:0] ST_OK   = 3'd0;
  localparam logic [2:0] ST_NEG  = 3'd1;
  localparam logic [2:0] ST_DZ   = 3'd2;
  localparam logic [2:0] ST_FRAC = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ISSUE,
    S_CAPTURE,
    S_SHOW,
    S_ERROR
  } state_t;

  function automatic logic is_op(logic [3:0] v);
    return (v == OP_ADD) || (v == OP_SUB) ||
           (v == OP_MUL) || (v == OP_DIV);
  endfunction

  // {frac, err, neg}; unknown codes show as a plain value
  function automatic logic [2:0] flags_of(logic [2:0] c);
    logic [2:0] f;
    f = 3'b000;
    unique case (c)
      ST_OK:   f = 3'b000;
      ST_NEG:  f = 3'b001;
      ST_DZ:   f = 3'b010;
      ST_FRAC: f = 3'b100;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/calc_edge_det.sv
// Per-bit registered rising-edge detector
// with synchronous active-low reset.
module calc_edge_det #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= '0;
      rise <= '0;
    end else begin
      hist <= din;
      rise <= din & ~hist;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: latches operands/op,
// issues a clean op edge to the ALU, captures result.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int GAP_CYC    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic       btn_load_a,
  input  logic       btn_load_b,
  input  logic [3:0] btn_op,
  input  logic       btn_eq,
  input  logic       btn_clr,
  output logic [3:0] reg_1_to_alu,
  output logic [3:0] reg_2_to_alu,
  output logic [3:0] arif_to_alu,
  input  logic [7:0] ind_1,
  input  logic [2:0] control,
  output logic [7:0] disp_value,
  output logic       disp_neg,
  output logic       disp_err,
  output logic       disp_frac,
  output logic       busy,
  output logic       done
);

  localparam int MAXC = (SETTLE_CYC > GAP_CYC) ?
                        SETTLE_CYC : GAP_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);

  logic [7:0]    rise;
  logic [3:0]    op_r;
  logic [2:0]    flg;
  logic [CW-1:0] cnt, cnt_n;
  state_t        state, state_n;
  logic          idle_like;
  logic          start;

  calc_edge_det #(.WIDTH(8)) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({btn_clr, btn_eq, btn_load_b,
            btn_load_a, btn_op}),
    .rise (rise)
  );

  assign idle_like = (state == S_IDLE) ||
                     (state == S_SHOW) ||
                     (state == S_ERROR);
  assign start = idle_like && rise[6] && (op_r != '0);
  assign busy  = !idle_like;
  assign flg   = flags_of(control);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (rise[7]) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        S_IDLE, S_SHOW, S_ERROR: begin
          if (start) begin
            state_n = S_GAP;
            cnt_n   = '0;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state_n = S_ISSUE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (cnt == SET_LAST) begin
            state_n = S_CAPTURE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          state_n = (control == ST_DZ) ? S_ERROR : S_SHOW;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      reg_1_to_alu <= '0;
      reg_2_to_alu <= '0;
      op_r         <= '0;
      arif_to_alu  <= '0;
      disp_value   <= '0;
      disp_neg     <= 1'b0;
      disp_err     <= 1'b0;
      disp_frac    <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= 1'b0;
      // op stays on the bus through CAPTURE so ind_1 is sampled settled
      arif_to_alu <= (state_n == S_ISSUE ||
                      state_n == S_CAPTURE) ? op_r : '0;
      if (rise[7]) begin
        reg_1_to_alu <= '0;
        reg_2_to_alu <= '0;
        op_r         <= '0;
        disp_value   <= '0;
        disp_neg     <= 1'b0;
        disp_err     <= 1'b0;
        disp_frac    <= 1'b0;
      end else if (state == S_CAPTURE) begin
        disp_value <= (control == ST_DZ) ? 8'd0 : ind_1;
        disp_neg   <= flg[0];
        disp_err   <= flg[1];
        disp_frac  <= flg[2];
        done       <= 1'b1;
      end else if (idle_like && !start) begin
        if (rise[4]) reg_1_to_alu <= sw_a;
        if (rise[5]) reg_2_to_alu <= sw_b;
        if (is_op(rise[3:0])) op_r <= rise[3:0];
      end
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: bench-side ALU,
// transaction-level model, directed + random stimulus.
module tb_calc_seq_ctrl;

  localparam int GAP    = 1;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_a = '0, sw_b = '0;
  logic [7:0] btn = '0;
  logic [3:0] reg_1_to_alu, reg_2_to_alu, arif_to_alu;
  logic [7:0] ind_1, disp_value;
  logic [2:0] control;
  logic [2:0] force_ctrl = '0;
  logic       disp_neg, disp_err, disp_frac, busy, done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  calc_seq_ctrl #(.SETTLE_CYC(SETTLE), .GAP_CYC(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_a        (sw_a),
    .sw_b        (sw_b),
    .btn_load_a  (btn[4]),
    .btn_load_b  (btn[5]),
    .btn_op      (btn[3:0]),
    .btn_eq      (btn[6]),
    .btn_clr     (btn[7]),
    .reg_1_to_alu(reg_1_to_alu),
    .reg_2_to_alu(reg_2_to_alu),
    .arif_to_alu (arif_to_alu),
    .ind_1       (ind_1),
    .control     (control),
    .disp_value  (disp_value),
    .disp_neg    (disp_neg),
    .disp_err    (disp_err),
    .disp_frac   (disp_frac),
    .busy        (busy),
    .done        (done)
  );

  // bench ALU: returns {control, value}
  function automatic logic [10:0] alu_f(input logic [3:0] a,
      input logic [3:0] b, input logic [3:0] op,
      input logic [2:0] fc);
    int ia, ib;
    logic [7:0] v;
    logic [2:0] c;
    ia = int'(a);
    ib = int'(b);
    v = 8'hA5;
    c = 3'd3;
    case (op)
      4'd1: begin v = 8'(ia + ib); c = 3'd0; end
      4'd2: begin
        if (ia >= ib) begin v = 8'(ia - ib); c = 3'd0; end
        else begin v = 8'(ib - ia); c = 3'd1; end
      end
      4'd4: begin v = 8'(ia * ib); c = 3'd0; end
      4'd8: begin
        if (ib == 0) begin v = 8'hFF; c = 3'd2; end
        else if (ia % ib == 0) begin v = 8'(ia / ib); c = 3'd0; end
        else begin v = 8'((ia * 100) / ib); c = 3'd4; end
      end
      default: ;
    endcase
    if (fc != 3'd0) c = fc;
    return {c, v};
  endfunction

  assign {control, ind_1} =
    alu_f(reg_1_to_alu, reg_2_to_alu, arif_to_alu, force_ctrl);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // model: m_t counts cycles since a calculation was accepted (-1 = not busy)
  logic [3:0] m_a, m_b, m_op;
  logic [7:0] m_dv, m_hist, m_rq;
  logic       m_neg, m_err, m_frac, m_done;
  int         m_t;

  always @(posedge clk) begin : model
    logic [7:0] ev;
    logic [10:0] r;
    if (!rst_n) begin
      m_a = '0; m_b = '0; m_op = '0; m_dv = '0;
      m_neg = 0; m_err = 0; m_frac = 0; m_done = 0;
      m_hist = '0; m_rq = '0; m_t = -1;
    end else begin
      ev = m_rq;
      m_rq = btn & ~m_hist;
      m_hist = btn;
      m_done = 0;
      if (ev[7]) begin
        m_a = '0; m_b = '0; m_op = '0; m_dv = '0;
        m_neg = 0; m_err = 0; m_frac = 0; m_t = -1;
      end else if (m_t >= 0) begin
        if (m_t == GAP + SETTLE) begin
          r = alu_f(m_a, m_b, m_op, force_ctrl);
          m_neg  = (r[10:8] == 3'd1);
          m_err  = (r[10:8] == 3'd2);
          m_frac = (r[10:8] == 3'd4);
          m_dv   = m_err ? 8'd0 : r[7:0];
          m_done = 1;
          m_t = -1;
        end else begin
          m_t++;
        end
      end else if (ev[6] && m_op != 0) begin
        m_t = 0;
      end else begin
        if (ev[4]) m_a = sw_a;
        if (ev[5]) m_b = sw_b;
        if ($countones(ev[3:0]) == 1) m_op = ev[3:0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("reg_1", reg_1_to_alu, m_a);
      chk("reg_2", reg_2_to_alu, m_b);
      chk("arif", arif_to_alu,
          (m_t >= GAP && m_t <= GAP + SETTLE) ? m_op : 0);
      chk("busy", busy, (m_t >= 0) ? 1 : 0);
      chk("done", done, m_done);
      chk("disp_value", disp_value, m_dv);
      chk("disp_neg", disp_neg, m_neg);
      chk("disp_err", disp_err, m_err);
      chk("disp_frac", disp_frac, m_frac);
    end
  end

  logic [3:0] prev_arif = '0;
  bit saw04 = 0;
  always @(negedge clk) begin
    if (prev_arif == 4'd0 && arif_to_alu == 4'd4) saw04 = 1;
    prev_arif = arif_to_alu;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [7:0] m);
    btn = m;
    tick();
    btn = '0;
    tick();
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] op);
    sw_a = a;
    sw_b = b;
    press(8'h10);
    press(8'h20);
    press({4'h0, op});
  endtask

  // pulse eq; lat = cycles from the sampling edge to done
  task automatic run_eq(output int lat);
    lat = -1;
    btn = 8'h40;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done && lat < 0) lat = n - 1;
      #1;
      if (n == 1) btn = '0;
      if (lat >= 0) break;
    end
  endtask

  int lat, cnt;

  initial begin
    tick();
    chk_en = 1;
    repeat (2) tick();
    chk("rst_value", disp_value, 0);
    chk("rst_arif", arif_to_alu, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    load(4'd3, 4'd5, 4'd1);
    run_eq(lat);
    chk("add_latency", lat, 5);
    chk("add_value", disp_value, 8);
    chk("add_flags", {disp_neg, disp_err, disp_frac}, 0);

    load(4'd2, 4'd7, 4'd2);
    run_eq(lat);
    chk("sub_value", disp_value, 5);
    chk("sub_neg", disp_neg, 1);
    sw_a = 4'd9;
    press(8'h10);
    run_eq(lat);
    chk("sub2_value", disp_value, 2);
    chk("sub2_neg", disp_neg, 0);

    load(4'd3, 4'd4, 4'd8);
    run_eq(lat);
    chk("div_value", disp_value, 75);
    chk("div_frac", disp_frac, 1);
    sw_b = 4'd0;
    press(8'h20);
    run_eq(lat);
    chk("dz_latency", lat, 5);
    chk("dz_err", disp_err, 1);
    chk("dz_value", disp_value, 0);

    load(4'd7, 4'd9, 4'd4);
    saw04 = 0;
    cnt = 0;
    btn = 8'h40;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
      #1;
      if (n == 9) btn = '0;
    end
    chk("held_eq_dones", cnt, 1);
    chk("mul_value", disp_value, 63);
    chk("mul_edge", saw04, 1);

    btn = 8'h40;
    tick();
    btn = '0;
    cnt = 0;
    while (arif_to_alu == 4'd0 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("issue_seen", (arif_to_alu != 0) ? 1 : 0, 1);
    press(8'h80);
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
      #1;
    end
    chk("clr_no_done", cnt, 0);
    chk("clr_value", disp_value, 0);
    chk("clr_arif", arif_to_alu, 0);
    chk("clr_busy", busy, 0);

    press(8'h40);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (busy) cnt++;
    end
    chk("noop_busy", cnt, 0);
    load(4'd6, 4'd2, 4'd2);
    press(8'h03);
    run_eq(lat);
    chk("multi_op_ignored", disp_value, 4);

    for (int c = 0; c < 3000; c++) begin
      sw_a = 4'($urandom);
      sw_b = 4'($urandom);
      for (int i = 0; i < 7; i++)
        if ($urandom_range(0, 3) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 39) == 0) btn[7] = ~btn[7];
      if (c % 250 == 0)
        case ($urandom_range(0, 4))
          0: force_ctrl = 3'd3;
          1: force_ctrl = 3'd5;
          2: force_ctrl = 3'd6;
          3: force_ctrl = 3'd7;
          default: force_ctrl = 3'd0;
        endcase
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      tick();
    end

    btn = '0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
